// File: rtl/smiley_motion_ctrl.sv
// smiley_motion_ctrl
// Per-frame sprite motion sequencer for the 640x480 VGA pipeline. On the first
// pixel of vertical blanking (optionally every FRAME_DIV frames) it computes a
// new sprite top-left position in shadow registers over three clocks and then
// commits it, so the pattern generator never sees a half-updated position.
// Optional feature macro: SMILEY_AUTO_COLOR_EN (bump o_color_idx on wall bounces).
module smiley_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SPRITE_W  = 64,
  parameter int SPRITE_H  = 64,
  parameter int X_INIT    = 288,
  parameter int Y_INIT    = 208,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_counter_x,
  input  logic [9:0] i_counter_y,
  input  logic [2:0] i_speed,
  input  logic       i_pause,
  output logic [9:0] o_sprite_x,
  output logic [9:0] o_sprite_y,
  output logic       o_dir_x,
  output logic       o_dir_y,
  output logic       o_frame_tick,
  output logic       o_update,
  output logic [2:0] o_color_idx
);

  // Bounce limits for the top-left corner; arithmetic is done in 11 bits so
  // pos + speed can never wrap before being compared against the limit.
  localparam logic [10:0] XMAX  = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0] YMAX  = 11'(V_ACTIVE - SPRITE_H);
  localparam logic [9:0]  EVT_Y = 10'(V_ACTIVE);
  localparam logic [9:0]  XRST  = 10'(X_INIT);
  localparam logic [9:0]  YRST  = 10'(Y_INIT);

  // Frame divider width; a divider of 1 still gets a 1-bit counter that stays 0.
  localparam int              FDW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FDW-1:0]  FDIV_LAST = FDW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_CALC_X = 2'd1,
    S_CALC_Y = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t state, state_nx;

  logic           frame_evt;
  logic           upd_due;
  logic           start;
  logic [FDW-1:0] fdiv;
  logic [2:0]     speed_q;

  // Shadow copy of position/direction; only the commit edge makes it visible.
  logic [9:0]     shadow_x, shadow_y;
  logic           shadow_dir_x, shadow_dir_y;

  // One-axis step results: {flip, next position}.
  logic [10:0]    step_x, step_y;

  // One bounce step on a single axis. Moving toward the far wall clamps to
  // lim and flips; moving toward zero clamps to 0 and flips once the step
  // would reach or cross the origin.
  function automatic logic [10:0] bounce(input logic [9:0]  pos,
                                         input logic        dir,
                                         input logic [2:0]  spd,
                                         input logic [10:0] lim);
    logic [10:0] sum;
    logic [10:0] res;
    sum = {1'b0, pos} + {8'd0, spd};
    if (dir) begin
      if (sum >= lim) res = {1'b1, lim[9:0]};
      else            res = {1'b0, sum[9:0]};
    end else begin
      if ({1'b0, pos} <= {8'd0, spd}) res = {1'b1, 10'd0};
      else                            res = {1'b0, pos - {7'd0, spd}};
    end
    return res;
  endfunction

  assign frame_evt = (i_counter_x == 10'd0) && (i_counter_y == EVT_Y);
  assign upd_due   = (fdiv == FDIV_LAST);
  assign step_x    = bounce(shadow_x, shadow_dir_x, speed_q, XMAX);
  assign step_y    = bounce(shadow_y, shadow_dir_y, speed_q, YMAX);

  // Sequencer state register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_WAIT;
    else          state <= state_nx;
  end

  // Next-state decode; a sequence only starts from S_WAIT, so frame events
  // that land mid-sequence are dropped here (the divider still counts them).
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      S_WAIT: begin
        if (frame_evt && upd_due && !i_pause && (i_speed != 3'd0)) begin
          state_nx = S_CALC_X;
          start    = 1'b1;
        end
      end
      S_CALC_X: state_nx = S_CALC_Y;
      S_CALC_Y: state_nx = S_COMMIT;
      S_COMMIT: state_nx = S_WAIT;
      default:  state_nx = S_WAIT;
    endcase
  end

  // Frame tick pulse and frame divider, both driven by every frame event.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_tick <= 1'b0;
      fdiv         <= '0;
    end else begin
      o_frame_tick <= frame_evt;
      if (frame_evt) fdiv <= upd_due ? '0 : fdiv + 1'b1;
    end
  end

  // Speed latch at sequence start, then x and y shadow steps on successive clocks.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      speed_q      <= 3'd0;
      shadow_x     <= XRST;
      shadow_y     <= YRST;
      shadow_dir_x <= 1'b1;
      shadow_dir_y <= 1'b1;
    end else begin
      if (start) speed_q <= i_speed;
      if (state == S_CALC_X) begin
        shadow_x     <= step_x[9:0];
        shadow_dir_x <= shadow_dir_x ^ step_x[10];
      end
      if (state == S_CALC_Y) begin
        shadow_y     <= step_y[9:0];
        shadow_dir_y <= shadow_dir_y ^ step_y[10];
      end
    end
  end

  // Commit shadows to the visible outputs and pulse o_update for one cycle.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sprite_x <= XRST;
      o_sprite_y <= YRST;
      o_dir_x    <= 1'b1;
      o_dir_y    <= 1'b1;
      o_update   <= 1'b0;
    end else begin
      o_update <= (state == S_COMMIT);
      if (state == S_COMMIT) begin
        o_sprite_x <= shadow_x;
        o_sprite_y <= shadow_y;
        o_dir_x    <= shadow_dir_x;
        o_dir_y    <= shadow_dir_y;
      end
    end
  end

`ifdef SMILEY_AUTO_COLOR_EN
  logic bounced;

  // Remember whether either axis hit a wall during this sequence; a corner
  // hit still counts as a single bounce.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bounced <= 1'b0;
    end else begin
      if (start)                                  bounced <= 1'b0;
      else if (state == S_CALC_X && step_x[10])   bounced <= 1'b1;
      else if (state == S_CALC_Y && step_y[10])   bounced <= 1'b1;
    end
  end

  // Advance the colour index on commits that followed a bounce.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                          o_color_idx <= 3'd0;
    else if (state == S_COMMIT && bounced) o_color_idx <= o_color_idx + 3'd1;
  end
`else
  assign o_color_idx = 3'd0;
`endif

endmodule

// File: tb/tb_smiley_motion_ctrl.sv
// Bench for smiley_motion_ctrl: three instances (default, FRAME_DIV=3, and one
// started near the top-right wall) share counters and reset; each has its own
// speed/pause and is checked against a position/bounce model kept in ints.
`timescale 1ns/1ps
module tb_smiley_motion_ctrl;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] cx, cy;
  logic [2:0] spd [N];
  logic       pau [N];
  logic [9:0] sx  [N];
  logic [9:0] sy  [N];
  logic       dxo [N];
  logic       dyo [N];
  logic       tick[N];
  logic       upd [N];
  logic [2:0] col [N];

  int checks = 0;
  int failures = 0;
  int mx[N], my[N], mdx[N], mdy[N], mcol[N], mfd[N];
  int tick_cnt[N], upd_cnt[N];

  always #20 clk = ~clk;

  smiley_motion_ctrl u_dut (
    .clk(clk), .i_rst_n(rst_n), .i_counter_x(cx), .i_counter_y(cy),
    .i_speed(spd[0]), .i_pause(pau[0]), .o_sprite_x(sx[0]), .o_sprite_y(sy[0]),
    .o_dir_x(dxo[0]), .o_dir_y(dyo[0]), .o_frame_tick(tick[0]), .o_update(upd[0]),
    .o_color_idx(col[0]));

  smiley_motion_ctrl #(.FRAME_DIV(3)) u_div (
    .clk(clk), .i_rst_n(rst_n), .i_counter_x(cx), .i_counter_y(cy),
    .i_speed(spd[1]), .i_pause(pau[1]), .o_sprite_x(sx[1]), .o_sprite_y(sy[1]),
    .o_dir_x(dxo[1]), .o_dir_y(dyo[1]), .o_frame_tick(tick[1]), .o_update(upd[1]),
    .o_color_idx(col[1]));

  smiley_motion_ctrl #(.X_INIT(572), .Y_INIT(253)) u_cor (
    .clk(clk), .i_rst_n(rst_n), .i_counter_x(cx), .i_counter_y(cy),
    .i_speed(spd[2]), .i_pause(pau[2]), .o_sprite_x(sx[2]), .o_sprite_y(sy[2]),
    .o_dir_x(dxo[2]), .o_dir_y(dyo[2]), .o_frame_tick(tick[2]), .o_update(upd[2]),
    .o_color_idx(col[2]));

  function automatic int fdiv_of(input int i); return (i == 1) ? 3 : 1; endfunction
  function automatic int xinit(input int i);   return (i == 2) ? 572 : 288; endfunction
  function automatic int yinit(input int i);   return (i == 2) ? 253 : 208; endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = xinit(i); my[i] = yinit(i);
      mdx[i] = 1; mdy[i] = 1; mcol[i] = 0; mfd[i] = 0;
    end
  endtask

  // Reference: one axis moves s pixels, stopping at the wall and reversing.
  task automatic move_axis(inout int p, inout int d, input int s, input int lim,
                           output bit flip);
    flip = 1'b0;
    if (d == 1) begin
      if (p + s >= lim) begin p = lim; d = 0; flip = 1'b1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1; flip = 1'b1; end
      else p = p - s;
    end
  endtask

  task automatic set_all(input int s, input bit p);
    for (int i = 0; i < N; i++) begin spd[i] = 3'(s); pau[i] = p; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_model_state(input int i, input string tag);
    checks++;
    if (sx[i] !== 10'(mx[i]) || sy[i] !== 10'(my[i]) || dxo[i] !== 1'(mdx[i]) ||
        dyo[i] !== 1'(mdy[i]) || col[i] !== 3'(mcol[i])) begin
      failures++;
      $display("FAIL %s inst%0d: got x=%0d y=%0d dx=%0b dy=%0b col=%0d want x=%0d y=%0d dx=%0d dy=%0d col=%0d",
               tag, i, sx[i], sy[i], dxo[i], dyo[i], col[i], mx[i], my[i], mdx[i], mdy[i], mcol[i]);
    end
  endtask

  // Present one frame event and follow the next six cycles: tick right after
  // the event edge, position held for two cycles, commit + o_update on the third.
  task automatic do_frame();
    int ox[N], oy[N];
    bit ue[N];
    bit due, fx, fy;
    for (int i = 0; i < N; i++) begin
      ox[i] = mx[i]; oy[i] = my[i];
      due = (mfd[i] == fdiv_of(i) - 1);
      mfd[i] = due ? 0 : mfd[i] + 1;
      ue[i] = due && !pau[i] && (spd[i] != 3'd0);
      if (ue[i]) begin
        move_axis(mx[i], mdx[i], int'(spd[i]), 576, fx);
        move_axis(my[i], mdy[i], int'(spd[i]), 416, fy);
`ifdef SMILEY_AUTO_COLOR_EN
        if (fx || fy) mcol[i] = (mcol[i] + 1) % 8;
`endif
      end
    end
    cx = 10'd0; cy = 10'd480;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        tick_cnt[i] += int'(tick[i]);
        upd_cnt[i]  += int'(upd[i]);
        checks++;
        if (tick[i] !== (k == 0)) begin
          failures++;
          $display("FAIL frame_tick inst%0d cycle%0d: got %b want %b", i, k, tick[i], (k == 0));
        end
        checks++;
        if (upd[i] !== (ue[i] && k == 3)) begin
          failures++;
          $display("FAIL update_pulse inst%0d cycle%0d: got %b want %b", i, k, upd[i], (ue[i] && k == 3));
        end
        if (k == 2) begin
          checks++;
          if (sx[i] !== 10'(ox[i]) || sy[i] !== 10'(oy[i])) begin
            failures++;
            $display("FAIL early_commit inst%0d: got (%0d,%0d) want (%0d,%0d)", i, sx[i], sy[i], ox[i], oy[i]);
          end
        end
        if (k == 3) check_model_state(i, "commit");
      end
      if (k == 0) cx = 10'd1;
    end
    cy = 10'd100;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cx = 10'd0; cy = 10'd0;
    set_all(0, 1'b0);
    model_reset();
    for (int i = 0; i < N; i++) begin tick_cnt[i] = 0; upd_cnt[i] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_model_state(i, "reset");
      checks++;
      if (tick[i] !== 1'b0 || upd[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_pulses inst%0d: got tick=%b upd=%b want 0 0", i, tick[i], upd[i]);
      end
    end
  endtask

  // Counters wander everywhere except the event pixel: no tick, no update.
  task automatic test_scan(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      cx = 10'($urandom_range(0, 799));
      cy = 10'($urandom_range(0, 524));
      if (c % 4 == 0) cy = 10'd480;
      if (c % 4 == 1) cx = 10'd0;
      if (cx == 10'd0 && cy == 10'd480) cx = 10'd5;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (tick[i] !== 1'b0 || upd[i] !== 1'b0) begin
          failures++;
          $display("FAIL idle_scan inst%0d at (%0d,%0d): got tick=%b upd=%b want 0 0", i, cx, cy, tick[i], upd[i]);
        end
      end
    end
  endtask

  task automatic test_first_frame();
    set_all(0, 1'b0);
    spd[0] = 3'd2;
    test_scan(40);
    do_frame();
    checks++;
    if (sx[0] !== 10'd290 || sy[0] !== 10'd210 || dxo[0] !== 1'b1 || dyo[0] !== 1'b1) begin
      failures++;
      $display("FAIL first_frame: got (%0d,%0d) dirs %b%b want (290,210) dirs 11", sx[0], sy[0], dxo[0], dyo[0]);
    end
  endtask

  task automatic test_edge_x();
    int c0;
    apply_reset();
    set_all(0, 1'b1);
    pau[0] = 1'b0; spd[0] = 3'd7;
    repeat (41) do_frame();
    checks++;
    if (sx[0] !== 10'd575 || dxo[0] !== 1'b1) begin
      failures++;
      $display("FAIL edge_x_approach: got x=%0d dx=%b want x=575 dx=1", sx[0], dxo[0]);
    end
    c0 = mcol[0];
    spd[0] = 3'd4;
    do_frame();
    checks++;
    if (sx[0] !== 10'd576 || dxo[0] !== 1'b0) begin
      failures++;
      $display("FAIL edge_x_hit: got x=%0d dx=%b want x=576 dx=0", sx[0], dxo[0]);
    end
    checks++;
`ifdef SMILEY_AUTO_COLOR_EN
    if (col[0] !== 3'((c0 + 1) % 8)) begin
      failures++;
      $display("FAIL edge_x_color: got %0d want %0d", col[0], (c0 + 1) % 8);
    end
`else
    if (col[0] !== 3'd0 || c0 != 0) begin
      failures++;
      $display("FAIL edge_x_color: got %0d want 0", col[0]);
    end
`endif
  endtask

  // Walk u_cor from (572,253) to (3,2) heading up-left, then hit the corner.
  task automatic test_corner();
    int c0;
    apply_reset();
    set_all(0, 1'b1);
    pau[2] = 1'b0;
    spd[2] = 3'd4; do_frame();
    spd[2] = 3'd7; repeat (22) do_frame();
    spd[2] = 3'd5; do_frame();
    spd[2] = 3'd7; repeat (59) do_frame();
    spd[2] = 3'd1; do_frame();
    checks++;
    if (sx[2] !== 10'd3 || sy[2] !== 10'd2 || dxo[2] !== 1'b0 || dyo[2] !== 1'b0) begin
      failures++;
      $display("FAIL corner_approach: got (%0d,%0d) dirs %b%b want (3,2) dirs 00", sx[2], sy[2], dxo[2], dyo[2]);
    end
    c0 = mcol[2];
    spd[2] = 3'd5; do_frame();
    checks++;
    if (sx[2] !== 10'd0 || sy[2] !== 10'd0 || dxo[2] !== 1'b1 || dyo[2] !== 1'b1) begin
      failures++;
      $display("FAIL corner_hit: got (%0d,%0d) dirs %b%b want (0,0) dirs 11", sx[2], sy[2], dxo[2], dyo[2]);
    end
    checks++;
`ifdef SMILEY_AUTO_COLOR_EN
    if (col[2] !== 3'((c0 + 1) % 8)) begin
      failures++;
      $display("FAIL corner_color: got %0d want %0d", col[2], (c0 + 1) % 8);
    end
`else
    if (col[2] !== 3'd0 || c0 != 0) begin
      failures++;
      $display("FAIL corner_color: got %0d want 0", col[2]);
    end
`endif
  endtask

  task automatic test_frame_div();
    int t0, u0;
    apply_reset();
    set_all(0, 1'b1);
    pau[1] = 1'b0; spd[1] = 3'd1;
    t0 = tick_cnt[1]; u0 = upd_cnt[1];
    repeat (6) do_frame();
    checks++;
    if (tick_cnt[1] - t0 != 6 || upd_cnt[1] - u0 != 2) begin
      failures++;
      $display("FAIL frame_div_counts: got ticks=%0d updates=%0d want 6 2", tick_cnt[1] - t0, upd_cnt[1] - u0);
    end
    checks++;
    if (sx[1] !== 10'd290) begin
      failures++;
      $display("FAIL frame_div_x: got %0d want 290", sx[1]);
    end
  endtask

  task automatic test_pause();
    int u0, x0, y0;
    set_all(0, 1'b1);
    u0 = upd_cnt[0]; x0 = mx[0]; y0 = my[0];
    spd[0] = 3'd3; pau[0] = 1'b1;
    repeat (2) do_frame();
    spd[0] = 3'd0; pau[0] = 1'b0;
    repeat (2) do_frame();
    checks++;
    if (upd_cnt[0] != u0 || sx[0] !== 10'(x0) || sy[0] !== 10'(y0)) begin
      failures++;
      $display("FAIL pause_hold: got updates=%0d pos (%0d,%0d) want updates=%0d pos (%0d,%0d)",
               upd_cnt[0] - u0, sx[0], sy[0], 0, x0, y0);
    end
    spd[0] = 3'd3;
    do_frame();
    checks++;
    if (upd_cnt[0] != u0 + 1) begin
      failures++;
      $display("FAIL pause_resume: got updates=%0d want 1", upd_cnt[0] - u0);
    end
  endtask

  // Reset lands while the x shadow is done and y is being computed.
  task automatic test_reset_mid();
    set_all(0, 1'b0);
    spd[0] = 3'd3; spd[1] = 3'd3; spd[2] = 3'd3;
    cx = 10'd0; cy = 10'd480;
    @(posedge clk);
    @(negedge clk);
    cx = 10'd1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) check_model_state(i, "reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (upd[i] !== 1'b0) begin
          failures++;
          $display("FAIL reset_mid_update inst%0d cycle%0d: got %b want 0", i, c, upd[i]);
        end
      end
    end
    for (int i = 0; i < N; i++) check_model_state(i, "reset_mid_hold");
    do_frame();
  endtask

  task automatic test_random(input int frames);
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < N; i++) begin
        spd[i] = 3'($urandom_range(0, 7));
        pau[i] = ($urandom_range(0, 7) == 0);
      end
      do_frame();
      if ($urandom_range(0, 3) == 0) test_scan(int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_edge_x();
    test_corner();
    test_frame_div();
    test_pause();
    test_reset_mid();
    test_random(150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
